// File: rtl/m31_matvec_sequencer_if.sv
// Start/abort request and busy/done status between upstream control
// and the M31 matrix-vector sequencer.
interface m31_matvec_sequencer_if;
    logic start;
    logic abort;
    logic busy;
    logic done;

    modport master (
        output start,
        output abort,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        output busy,
        output done
    );
endinterface

// File: rtl/m31_matvec_sequencer.sv
// y = M*x over M31: one multi-cycle dot-product engine reused per row,
// restarted through its reset between rows, results latched into y.
module vector_dot_product_mc #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_WIDTH-1:0] vec1 [VECTOR_SIZE],
    input  logic [WORD_WIDTH-1:0] vec2 [VECTOR_SIZE],
    output logic [WORD_WIDTH-1:0] result,
    output logic                  valid
);
    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(VECTOR_SIZE + 2);
    localparam logic [W-1:0] P = '1;

    logic [CW-1:0] cnt_q;
    logic [W-1:0]  prod_q;
    logic [W-1:0]  acc_q;
    logic          pv_q;
    logic [W-1:0]  a_sel;
    logic [W-1:0]  b_sel;

    // 2^31 == 1 mod p, so the high half of the product folds onto the low half
    function automatic logic [W-1:0] mod_mul(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-1:0] pr;
        logic [W:0]     s;
        logic [W-1:0]   r;
        pr = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s  = {1'b0, pr[W-1:0]} + {1'b0, pr[2*W-1:W]};
        r  = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
        return (r == P) ? '0 : r;
    endfunction

    function automatic logic [W-1:0] mod_add(
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P})
            s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < VECTOR_SIZE; i++) begin
            if (cnt_q == CW'(i)) begin
                a_sel = vec1[i];
                b_sel = vec2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pv_q   <= 1'b0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (cnt_q != CW'(VECTOR_SIZE + 1))
                cnt_q <= cnt_q + CW'(1);
            pv_q   <= (cnt_q < CW'(VECTOR_SIZE));
            prod_q <= mod_mul(a_sel, b_sel);
            if (pv_q)
                acc_q <= mod_add(acc_q, prod_q);
        end
    end

    assign result = acc_q;
    assign valid  = (cnt_q == CW'(VECTOR_SIZE + 1));
endmodule

module m31_matvec_sequencer #(
    parameter int WORD_WIDTH  = 31,
    parameter int VECTOR_SIZE = 16,
    parameter int ROWS        = 8,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    m31_matvec_sequencer_if.slave ctl,
    input  logic [WORD_WIDTH-1:0] mat [ROWS][VECTOR_SIZE],
    input  logic [WORD_WIDTH-1:0] vec [VECTOR_SIZE],
    output logic [WORD_WIDTH-1:0] y [ROWS],
    output logic [RW-1:0]         row_idx
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [RW-1:0]         row_q;
    logic                  busy_q;
    logic                  done_q;
    logic [WORD_WIDTH-1:0] y_q [ROWS];
    logic [WORD_WIDTH-1:0] row_sel [VECTOR_SIZE];
    logic [WORD_WIDTH-1:0] eng_res;
    logic                  eng_valid;
    logic                  eng_rst;

    always_comb begin
        row_sel = mat[0];
        for (int i = 0; i < ROWS; i++) begin
            if (row_q == RW'(i))
                row_sel = mat[i];
        end
    end

    // engine only counts while RUN; CLEAR holds it cleared for the next row
    assign eng_rst = reset | (state_q != S_RUN);

    vector_dot_product_mc #(
        .WORD_WIDTH (WORD_WIDTH),
        .VECTOR_SIZE(VECTOR_SIZE)
    ) u_engine (
        .clk   (clk),
        .reset (eng_rst),
        .vec1  (row_sel),
        .vec2  (vec),
        .result(eng_res),
        .valid (eng_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < ROWS; i++)
                y_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (ctl.start) begin
                        state_q <= S_CLEAR;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (ctl.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (ctl.abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (eng_valid) begin
                        for (int i = 0; i < ROWS; i++) begin
                            if (row_q == RW'(i))
                                y_q[i] <= eng_res;
                        end
                        if (row_q == RW'(ROWS - 1)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            row_q   <= row_q + RW'(1);
                            state_q <= S_CLEAR;
                        end
                    end
                end
            endcase
        end
    end

    assign ctl.busy = busy_q;
    assign ctl.done = done_q;
    assign y        = y_q;
    assign row_idx  = row_q;
endmodule

// File: tb/tb_m31_matvec_sequencer.sv
// Vector table plus scoreboard bench for the M31 matrix-vector sequencer,
// covering full runs, back-to-back starts, abort, reset and ROWS=1.
module tb_m31_matvec_sequencer;
    localparam int V = 4;
    localparam int R = 2;
    localparam logic [30:0] PM1 = 31'h7FFFFFFE;

    typedef struct packed {
        logic [0:R*V-1][30:0] m;
        logic [0:V-1][30:0]   v;
        logic [30:0]          y0;
        logic [30:0]          y1;
        int                   dcyc;
    } tv_t;

    typedef struct packed {
        logic [30:0] y0;
        logic [30:0] y1;
        int          dcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb [$];
    tv_t         tab [3];

    logic [30:0] mat_a [R][V];
    logic [30:0] vec_a [V];
    logic [30:0] y_a [R];
    logic [0:0]  ri_a;
    logic [30:0] mat_b [1][V];
    logic [30:0] vec_b [V];
    logic [30:0] y_b [1];
    logic [0:0]  ri_b;

    m31_matvec_sequencer_if ia ();
    m31_matvec_sequencer_if ib ();

    m31_matvec_sequencer #(
        .WORD_WIDTH(31), .VECTOR_SIZE(V), .ROWS(R)
    ) dut (
        .clk(clk), .reset(reset), .ctl(ia),
        .mat(mat_a), .vec(vec_a), .y(y_a), .row_idx(ri_a)
    );

    m31_matvec_sequencer #(
        .WORD_WIDTH(31), .VECTOR_SIZE(V), .ROWS(1)
    ) dut1 (
        .clk(clk), .reset(reset), .ctl(ib),
        .mat(mat_b), .vec(vec_b), .y(y_b), .row_idx(ri_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic load(input tv_t t);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < V; c++)
                mat_a[r][c] = t.m[r*V+c];
        for (int c = 0; c < V; c++)
            vec_a[c] = t.v[c];
    endtask

    // called at a negedge right after start is raised
    task automatic watch(input int maxc, input bit hold);
        int t0;
        int c;
        exp_t e;
        t0 = cyc;
        for (int k = 0; k < maxc && sb.size() > 0; k++) begin
            @(negedge clk);
            c = cyc - t0;
            if (!hold && c == 1) ia.start = 1'b0;
            if (!hold && c == 5) ia.start = 1'b1;
            if (!hold && c == 6) ia.start = 1'b0;
            chk("busy", 32'(ia.busy), 32'((c % 15) != 0));
            if (c == 1) chk("row_idx_c1", 32'(ri_a), 32'd0);
            if (c == 8) chk("row_idx_c8", 32'(ri_a), 32'd1);
            if (ia.done) begin
                e = sb.pop_front();
                chk("done_cycle", 32'(c), 32'(e.dcyc));
                chk("y0", 32'(y_a[0]), 32'(e.y0));
                chk("y1", 32'(y_a[1]), 32'(e.y1));
                chk("row_idx_done", 32'(ri_a), 32'd1);
                if (sb.size() == 0) ia.start = 1'b0;
            end
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        ia.start = 1'b0;
    endtask

    task automatic idle_chk(input string nm);
        @(negedge clk);
        chk({nm, "_busy"}, 32'(ia.busy), 32'd0);
        chk({nm, "_done"}, 32'(ia.done), 32'd0);
    endtask

    initial begin
        int t0;
        int c;
        int ndone;
        bit seen;
        exp_t e;

        tab[0] = '{m: '{31'd1, 31'd2, 31'd3, 31'd4,
                        31'd5, 31'd6, 31'd7, 31'd8},
                   v: '{31'd1, 31'd1, 31'd1, 31'd1},
                   y0: 31'd10, y1: 31'd26, dcyc: 15};
        tab[1] = '{m: '{default: PM1}, v: '{default: PM1},
                   y0: 31'd4, y1: 31'd4, dcyc: 15};
        tab[2] = '{m: '{31'h7FFFFFFF, 31'd2, 31'd3, 31'h40000000,
                        31'd1, 31'd1, 31'd1, 31'd1},
                   v: '{31'd5, PM1, 31'd1, 31'd2},
                   y0: 31'd2, y1: 31'd7, dcyc: 15};

        reset = 1'b1;
        ia.start = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0;
        load(tab[0]);
        for (int c2 = 0; c2 < V; c2++) begin
            mat_b[0][c2] = '0;
            vec_b[c2] = 31'd1;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_y0", 32'(y_a[0]), 32'd0);
        chk("rst_y1", 32'(y_a[1]), 32'd0);
        chk("rst_busy", 32'(ia.busy), 32'd0);
        chk("rst_done", 32'(ia.done), 32'd0);
        chk("rst_row", 32'(ri_a), 32'd0);

        // table-driven full runs
        for (int i = 0; i < 3; i++) begin
            load(tab[i]);
            ia.start = 1'b1;
            sb.push_back('{y0: tab[i].y0, y1: tab[i].y1, dcyc: tab[i].dcyc});
            watch(40, 1'b0);
            idle_chk("post_run");
        end

        // start held high: back-to-back runs
        load(tab[0]);
        ia.start = 1'b1;
        sb.push_back('{y0: 31'd10, y1: 31'd26, dcyc: 15});
        sb.push_back('{y0: 31'd10, y1: 31'd26, dcyc: 30});
        watch(50, 1'b1);
        idle_chk("post_b2b");

        // abort during row 1 RUN
        for (int r = 0; r < R; r++)
            for (int c2 = 0; c2 < V; c2++)
                mat_a[r][c2] = (r == 0) ? 31'd2 : 31'd3;
        ia.start = 1'b1;
        t0 = cyc;
        ndone = 0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == 1) ia.start = 1'b0;
            if (ia.done) ndone++;
            if (c == 10) ia.abort = 1'b1;
        end
        chk("abort_busy", 32'(ia.busy), 32'd0);
        chk("abort_y0", 32'(y_a[0]), 32'd8);
        chk("abort_y1", 32'(y_a[1]), 32'd26);
        ia.abort = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ia.done || ia.busy) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // reset mid-operation
        load(tab[0]);
        ia.start = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (cyc - t0 == 1) ia.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_y0", 32'(y_a[0]), 32'd0);
        chk("mrst_y1", 32'(y_a[1]), 32'd0);
        chk("mrst_busy", 32'(ia.busy), 32'd0);
        chk("mrst_row", 32'(ri_a), 32'd0);
        ia.start = 1'b1;
        sb.push_back('{y0: 31'd10, y1: 31'd26, dcyc: 15});
        watch(40, 1'b0);

        // ROWS=1 instance: nonzero row, then zero row
        for (int j = 0; j < 2; j++) begin
            for (int c2 = 0; c2 < V; c2++)
                mat_b[0][c2] = (j == 0) ? 31'(c2 + 1) : 31'd0;
            ib.start = 1'b1;
            sb.push_back('{y0: (j == 0) ? 31'd10 : 31'd0, y1: 31'd0, dcyc: 8});
            t0 = cyc;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                c = cyc - t0;
                if (c == 1) ib.start = 1'b0;
                chk("r1_busy", 32'(ib.busy), 32'(c >= 1 && c <= 7));
                if (ib.done) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    chk("r1_done_cycle", 32'(c), 32'(e.dcyc));
                    chk("r1_y0", 32'(y_b[0]), 32'(e.y0));
                end
            end
            if (!seen) begin
                chk("r1_timeout", 32'(sb.size()), 32'd0);
                sb.delete();
            end
            ib.start = 1'b0;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
